keccak_squeeze_stream: RTL and testbench

Sequential squeeze controller that streams the Keccak digest or XOF output over a parametrised-width valid/ready stream. It replaces the single-window combinational output unit with one that:
- walks the rate portion of the state beat by beat;
- tracks the total requested output length;
- requests extra permutations from the Keccak core when the rate is exhausted;
- honours downstream backpressure.

It sits between the permutation core and the top-level output stream.

---
 rtl/keccak_squeeze_stream.sv | 169 ++++++++++++++++
 tb/tb_keccak_squeeze_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_stream.sv
// Squeeze controller: streams the rate portion of the Keccak state as DWIDTH-bit beats,
// requesting further permutations until the requested output length has been delivered.
module keccak_squeeze_stream #(
  parameter int DWIDTH         = 256,
  parameter int LEN_WIDTH      = 32,
  parameter int MODE_SEL_WIDTH = 3,
  parameter int RATE_WIDTH     = 11,
  parameter int ROW_SIZE       = 5,
  parameter int COL_SIZE       = 5,
  parameter int LANE_SIZE      = 64
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              start_i,
  input  logic                                              stop_i,
  input  logic [MODE_SEL_WIDTH-1:0]                         keccak_mode_i,
  input  logic [RATE_WIDTH-1:0]                             rate_i,
  input  logic [LEN_WIDTH-1:0]                              out_len_i,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  state_array_i,
  output logic                                              perm_req_o,
  input  logic                                              perm_done_i,
  output logic [DWIDTH-1:0]                                 data_o,
  output logic [DWIDTH/8-1:0]                               keep_o,
  output logic                                              valid_o,
  input  logic                                              ready_i,
  output logic                                              last_o,
  output logic                                              busy_o,
  output logic                                              done_o,
  output logic [1:0]                                        dbg_state_o
);

  localparam int BEAT_BYTES = DWIDTH / 8;
  localparam int STATE_BITS = ROW_SIZE * COL_SIZE * LANE_SIZE;
  // Byte counters must hold rate_i/8 (up to 255) and BEAT_BYTES (up to 168).
  localparam int CNT_W = 9;

  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_224 = MODE_SEL_WIDTH'(0);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = MODE_SEL_WIDTH'(1);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_384 = MODE_SEL_WIDTH'(2);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = MODE_SEL_WIDTH'(3);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 = MODE_SEL_WIDTH'(4);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 = MODE_SEL_WIDTH'(5);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_PERM = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     off;
  logic [CNT_W-1:0]     rate_bytes;
  logic [LEN_WIDTH-1:0] rem;
  logic                 unbounded;

  logic [STATE_BITS-1:0] flat;
  logic [DWIDTH-1:0]     window;
  logic [CNT_W-1:0]      space;
  logic [CNT_W-1:0]      cap;
  logic [CNT_W-1:0]      nb;
  logic [CNT_W-1:0]      off_next;
  logic [DWIDTH-1:0]     data_win;
  logic [BEAT_BYTES-1:0] keep_win;
  logic                  last_win;

  // Flat byte k = lane (5y+x), byte j of that lane, with k = 8*(5y+x)+j.
  always_comb begin
    flat = '0;
    for (int y = 0; y < COL_SIZE; y++) begin
      for (int x = 0; x < ROW_SIZE; x++) begin
        flat[LANE_SIZE*(ROW_SIZE*y+x) +: LANE_SIZE] = state_array_i[x][y];
      end
    end
  end

  // Bytes past the end of the state shift in as zero, which pads oversized windows.
  assign window = DWIDTH'(flat >> {off, 3'b000});

  always_comb begin
    space = rate_bytes - off;
    cap   = (space < CNT_W'(BEAT_BYTES)) ? space : CNT_W'(BEAT_BYTES);
    nb    = cap;
    if (!unbounded && (rem < LEN_WIDTH'(cap))) begin
      nb = CNT_W'(rem);
    end
    off_next = off + nb;
    last_win = !unbounded && (LEN_WIDTH'(nb) == rem);
    keep_win = '0;
    data_win = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      keep_win[i]       = (CNT_W'(i) < nb);
      data_win[8*i +: 8] = keep_win[i] ? window[8*i +: 8] : 8'h00;
    end
  end

  // Stream handshake: a beat transfers on a clock edge where valid_o && ready_i;
  // while valid_o is high and ready_i low, data_o/keep_o/last_o hold their value
  // because off/rem only move on a transfer and the state is stable outside PERM.
  assign valid_o     = (state == ST_OUT);
  assign perm_req_o  = (state == ST_PERM);
  assign busy_o      = (state != ST_IDLE);
  assign data_o      = valid_o ? data_win : '0;
  assign keep_o      = valid_o ? keep_win : '0;
  assign last_o      = valid_o & last_win;
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      off        <= '0;
      rate_bytes <= '0;
      rem        <= '0;
      unbounded  <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state     <= ST_IDLE;
        off       <= '0;
        rem       <= '0;
        unbounded <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              state      <= ST_OUT;
              off        <= '0;
              rate_bytes <= CNT_W'(rate_i >> 3);
              unbounded  <= 1'b0;
              case (keccak_mode_i)
                MODE_SHA3_224: rem <= LEN_WIDTH'(28);
                MODE_SHA3_256: rem <= LEN_WIDTH'(32);
                MODE_SHA3_384: rem <= LEN_WIDTH'(48);
                MODE_SHA3_512: rem <= LEN_WIDTH'(64);
                MODE_SHAKE128, MODE_SHAKE256: begin
                  rem       <= out_len_i;
                  unbounded <= (out_len_i == '0);
                end
                default: rem <= LEN_WIDTH'(32);
              endcase
            end
          end
          ST_OUT: begin
            if (ready_i) begin
              off <= off_next;
              if (!unbounded) begin
                rem <= rem - LEN_WIDTH'(nb);
              end
              if (last_win) begin
                state  <= ST_IDLE;
                done_o <= 1'b1;
              end else if (off_next == rate_bytes) begin
                state <= ST_PERM;
              end
            end
          end
          ST_PERM: begin
            if (perm_done_i) begin
              off   <= '0;
              state <= ST_OUT;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_stream.sv
// Bench for keccak_squeeze_stream: table-driven runs against a byte-level reference model,
// plus hand-written sequences for stalls, unbounded streams, stop, reset and a 64-bit instance.
module tb_keccak_squeeze_stream;

  localparam int DW   = 256;
  localparam int BB   = DW / 8;
  localparam int W    = 1 + BB + DW;
  localparam int DW64 = 64;
  localparam int BB64 = DW64 / 8;
  localparam int W64  = 1 + BB64 + DW64;

  localparam logic [2:0] SHA3_224 = 3'd0;
  localparam logic [2:0] SHA3_256 = 3'd1;
  localparam logic [2:0] SHA3_384 = 3'd2;
  localparam logic [2:0] SHA3_512 = 3'd3;
  localparam logic [2:0] SHAKE128 = 3'd4;
  localparam logic [2:0] SHAKE256 = 3'd5;

  typedef struct {
    logic [2:0]  mode;
    logic [10:0] rate;
    logic [31:0] len;
    int          pct;
    int          beats;
    int          perms;
  } tc_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, stop = 1'b0, perm_done = 1'b0, ready = 1'b0;
  logic [2:0]  mode = '0;
  logic [10:0] rate = '0;
  logic [31:0] out_len = '0;
  logic [7:0]  seed = 8'h00;
  logic [4:0][4:0][63:0] state_arr;
  logic              perm_req, valid, last, busy, done;
  logic [DW-1:0]     data;
  logic [BB-1:0]     keep;
  logic [1:0]        dbg_state;

  logic              start64 = 1'b0, stop64 = 1'b0, perm_done64 = 1'b0, ready64 = 1'b1;
  logic              perm_req64, valid64, last64, busy64, done64;
  logic [DW64-1:0]   data64;
  logic [BB64-1:0]   keep64;
  logic [1:0]        dbg_state64;

  // State byte k = k + seed; seed advances on every permutation.
  always_comb begin
    state_arr = '0;
    for (int k = 0; k < 200; k++) begin
      state_arr[(k/8)%5][(k/8)/5][8*(k%8) +: 8] = 8'(k) + seed;
    end
  end

  keccak_squeeze_stream #(.DWIDTH(DW), .LEN_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .keccak_mode_i(mode), .rate_i(rate), .out_len_i(out_len),
    .state_array_i(state_arr), .perm_req_o(perm_req), .perm_done_i(perm_done),
    .data_o(data), .keep_o(keep), .valid_o(valid), .ready_i(ready),
    .last_o(last), .busy_o(busy), .done_o(done), .dbg_state_o(dbg_state)
  );

  keccak_squeeze_stream #(.DWIDTH(DW64), .LEN_WIDTH(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .stop_i(stop64),
    .keccak_mode_i(mode), .rate_i(rate), .out_len_i(out_len),
    .state_array_i(state_arr), .perm_req_o(perm_req64), .perm_done_i(perm_done64),
    .data_o(data64), .keep_o(keep64), .valid_o(valid64), .ready_i(ready64),
    .last_o(last64), .busy_o(busy64), .done_o(done64), .dbg_state_o(dbg_state64)
  );

  // scoreboard
  logic [W-1:0]   exp_q[$];
  logic [W64-1:0] exp64_q[$];
  int n_cmp = 0, n_err = 0;
  int beat_cnt = 0, done_cnt = 0, perm_cnt = 0, perm_wait = 0, perm_hi_cnt = 0;
  int beat64_cnt = 0, done64_cnt = 0, perm64_hi_cnt = 0;
  int rdy_pct = 100;
  bit rdy_pat[$];
  tc_t tbl[8];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  function automatic logic [7:0] sbyte(input int k, input logic [7:0] s);
    return (k < 200) ? 8'(k) + s : 8'h00;
  endfunction

  // Reference model: cut the requested byte stream into beats of at most bb bytes,
  // never crossing a rate boundary; each new rate block sees the next seed.
  task automatic model(input int bb, input logic [2:0] m, input logic [10:0] r,
                       input logic [31:0] len, input int max_beats);
    int total, sent, off, n, rb, beats;
    bit bounded, lst;
    logic [7:0] s;
    logic [DW-1:0] d;
    logic [BB-1:0] kp;
    rb = int'(r) / 8;
    bounded = 1'b1;
    total = 0;
    case (m)
      SHA3_224: total = 28;
      SHA3_256: total = 32;
      SHA3_384: total = 48;
      SHA3_512: total = 64;
      default: begin
        total = int'(len);
        bounded = (len != 0);
      end
    endcase
    s = 8'(perm_cnt);
    sent = 0; off = 0; beats = 0;
    while (beats < max_beats) begin
      n = bb;
      if (rb - off < n) n = rb - off;
      if (bounded && (total - sent < n)) n = total - sent;
      d = '0; kp = '0;
      for (int i = 0; i < n; i++) begin
        d[8*i +: 8] = sbyte(off + i, s);
        kp[i] = 1'b1;
      end
      lst = bounded && (sent + n == total);
      if (bb == BB) exp_q.push_back({lst, kp, d});
      else exp64_q.push_back({lst, kp[BB64-1:0], d[DW64-1:0]});
      beats++; sent += n; off += n;
      if (lst) break;
      if (off == rb) begin
        off = 0;
        s = s + 8'd1;
      end
    end
  endtask

  // One clock: monitor at the falling edge, then drive inputs just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL beat_unexpected: got %h required no beat", {last, keep, data});
      end else begin
        check("beat", {last, keep, data}, exp_q[0]);
        if (ready) begin
          void'(exp_q.pop_front());
          beat_cnt++;
        end
      end
    end
    if (valid64) begin
      if (exp64_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL beat64_unexpected: got %h required no beat", {last64, keep64, data64});
      end else begin
        check("beat64", W'({last64, keep64, data64}), W'(exp64_q[0]));
        if (ready64) begin
          void'(exp64_q.pop_front());
          beat64_cnt++;
        end
      end
    end
    if (done) done_cnt++;
    if (done64) done64_cnt++;
    if (perm_req) perm_hi_cnt++;
    if (perm_req64) perm64_hi_cnt++;
    if (perm_done) begin
      check_int("perm_req_held", int'(perm_req), 1);
      check_int("perm_valid_low", int'(valid), 0);
    end
    if (perm_req && !perm_done) perm_wait++;
    else if (!perm_req) perm_wait = 0;
    @(posedge clk);
    #1;
    if (perm_done) begin
      perm_done = 1'b0;
    end else if (perm_wait >= 3) begin
      perm_done = 1'b1;
      perm_cnt++;
      seed = 8'(perm_cnt);
      perm_wait = 0;
    end
    if (rdy_pat.size() > 0) ready = rdy_pat.pop_front();
    else ready = (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  task automatic run_case(input string name, input tc_t tc);
    int b0, d0, p0, h0;
    b0 = beat_cnt; d0 = done_cnt; p0 = perm_cnt; h0 = perm_hi_cnt;
    model(BB, tc.mode, tc.rate, tc.len, 1000);
    mode = tc.mode; rate = tc.rate; out_len = tc.len; rdy_pct = tc.pct;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_int({name, "_latency"}, int'(valid), 1);
    for (int c = 0; c < 600 && done_cnt == d0; c++) cycle();
    cycle();
    cycle();
    check_int({name, "_done"}, done_cnt - d0, 1);
    check_int({name, "_beats"}, beat_cnt - b0, tc.beats);
    check_int({name, "_perms"}, perm_cnt - p0, tc.perms);
    check_int({name, "_perm_cycles"}, perm_hi_cnt - h0, 4 * tc.perms);
    check_int({name, "_leftover"}, exp_q.size(), 0);
    check_int({name, "_busy"}, int'(busy), 0);
    exp_q.delete();
  endtask

  initial begin
    int b0, d0, p0;
    tbl[0] = '{SHA3_256, 11'd1088, 32'd0,   100, 1,  0};
    tbl[1] = '{SHA3_384, 11'd832,  32'd0,   60,  2,  0};
    tbl[2] = '{SHAKE128, 11'd1344, 32'd200, 100, 7,  1};
    tbl[3] = '{SHAKE256, 11'd1088, 32'd136, 100, 5,  0};
    tbl[4] = '{SHAKE256, 11'd1088, 32'd300, 70,  11, 2};
    tbl[5] = '{SHAKE128, 11'd1344, 32'd1,   100, 1,  0};
    tbl[6] = '{SHA3_224, 11'd1152, 32'd0,   50,  1,  0};
    tbl[7] = '{SHAKE128, 11'd1344, 32'd168, 100, 6,  0};

    #2 rst = 1'b1;
    #1;
    check("rst_beat", {last, keep, data}, '0);
    check_int("rst_valid", int'(valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_perm_req", int'(perm_req), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_state", int'(dbg_state), 0);
    check_int("rst_busy64", int'(busy64), 0);
    check_int("rst_state64", int'(dbg_state64), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < 8; t++) run_case($sformatf("tbl%0d", t), tbl[t]);

    // SHA3-512 with a 1/0/0/1 ready pattern: the second beat is compared on each stall cycle
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_case("sha512_stall", '{SHA3_512, 11'd576, 32'd0, 100, 2, 0});

    // Unbounded SHAKE256: runs across two permutations, then stop mid-stream
    b0 = beat_cnt; d0 = done_cnt; p0 = perm_cnt;
    model(BB, SHAKE256, 11'd1088, 32'd0, 13);
    mode = SHAKE256; rate = 11'd1088; out_len = 32'd0; rdy_pct = 80;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 600 && (beat_cnt - b0) < 12; c++) cycle();
    stop = 1'b1;
    ready = 1'b0;
    cycle();
    stop = 1'b0;
    check_int("xof_beats", beat_cnt - b0, 12);
    check_int("xof_perms", perm_cnt - p0, 2);
    check_int("xof_stop_valid", int'(valid), 0);
    check_int("xof_stop_busy", int'(busy), 0);
    check_int("xof_stop_perm_req", int'(perm_req), 0);
    cycle();
    check_int("xof_no_done", done_cnt - d0, 0);
    exp_q.delete();

    // stop beats a simultaneous start
    mode = SHA3_256; rate = 11'd1088;
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    check_int("stop_start_valid", int'(valid), 0);
    check_int("stop_start_busy", int'(busy), 0);

    // asynchronous reset during a stall, then restart from byte 0
    model(BB, SHA3_512, 11'd576, 32'd0, 1000);
    mode = SHA3_512; rate = 11'd576; rdy_pct = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    check_int("pre_rst_valid", int'(valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_beat", {last, keep, data}, '0);
    check_int("mid_rst_valid", int'(valid), 0);
    check_int("mid_rst_busy", int'(busy), 0);
    check_int("mid_rst_done", int'(done), 0);
    exp_q.delete();
    cycle();
    rst = 1'b0;
    run_case("restart", '{SHA3_256, 11'd1088, 32'd0, 100, 1, 0});

    // 64-bit instance, SHA3-224: beats of 8, 8, 8, 4 bytes
    b0 = beat64_cnt; d0 = done64_cnt; p0 = perm64_hi_cnt;
    model(BB64, SHA3_224, 11'd1152, 32'd0, 1000);
    mode = SHA3_224; rate = 11'd1152;
    start64 = 1'b1;
    cycle();
    start64 = 1'b0;
    check_int("dw64_latency", int'(valid64), 1);
    for (int c = 0; c < 100 && done64_cnt == d0; c++) cycle();
    cycle();
    check_int("dw64_done", done64_cnt - d0, 1);
    check_int("dw64_beats", beat64_cnt - b0, 4);
    check_int("dw64_perm_cycles", perm64_hi_cnt - p0, 0);
    check_int("dw64_leftover", exp64_q.size(), 0);
    check_int("dw64_busy", int'(busy64), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
